sfm_acc_den_inv_arbiter: RTL and testbench

- Shares one denominator-inverter pipeline between N_REQ accumulator lanes.
- Round-robin arbitrates the lanes' denominator requests onto the inverter input.
- Tracks the requester ID of every in-flight operation in a tag FIFO and routes each reciprocal back to its originating lane.
- Sits between the accumulator lanes and the inverter, and adds zero latency to the inverter path.

---
 rtl/sfm_acc_den_inv_arbiter.sv | 136 +++++++++++++
 tb/tb_sfm_acc_den_inv_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sfm_acc_den_inv_arbiter.sv
`default_nettype none
// ============================================================================
// sfm_acc_den_inv_arbiter : round-robin sharing of one denominator inverter
// between N_REQ accumulator lanes, with in-order tag return routing.
// Revision 1.0
// ============================================================================
module sfm_acc_den_inv_arbiter #(
  parameter int N_REQ        = 4,
  parameter int WIDTH        = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clear_i,
  input  logic [N_REQ-1:0]                      req_valid_i,
  input  logic [N_REQ*WIDTH-1:0]                req_den_i,
  output logic [N_REQ-1:0]                      req_ready_o,
  output logic [N_REQ-1:0]                      rsp_valid_o,
  output logic [WIDTH-1:0]                      rsp_inv_o,
  input  logic [N_REQ-1:0]                      rsp_ready_i,
  output logic                                  inv_valid_o,
  output logic [WIDTH-1:0]                      inv_den_o,
  input  logic                                  inv_ready_i,
  input  logic                                  inv_valid_i,
  input  logic [WIDTH-1:0]                      inv_res_i,
  output logic                                  inv_ready_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight_o,
  output logic                                  busy_o,
  output logic                                  err_o
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_INFLIGHT+1);
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [ID_W-1:0]  lock_id_q, lock_id_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ID_W-1:0]  tag_q [MAX_INFLIGHT];

  logic [ID_W-1:0]  scan_w;
  logic [ID_W-1:0]  sel_w;
  logic [ID_W-1:0]  head_w;
  logic             full_w, empty_w, push_w, pop_w;

  // Rotating priority scan starting at the round-robin pointer.
  always_comb begin
    scan_w = ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[ID_W'((int'(ptr_q) + i) % N_REQ)]) begin
        scan_w = ID_W'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  assign sel_w   = lock_q ? lock_id_q : scan_w;
  assign full_w  = (cnt_q == CNT_W'(MAX_INFLIGHT));
  assign empty_w = (cnt_q == '0);
  assign head_w  = tag_q[rd_ptr_q];

  assign inv_valid_o = (lock_q | (|req_valid_i)) & ~full_w;
  assign inv_den_o   = req_den_i[sel_w*WIDTH +: WIDTH];
  assign push_w      = inv_valid_o & inv_ready_i;

  assign inv_ready_o = ~empty_w & rsp_ready_i[head_w];
  assign rsp_inv_o   = inv_res_i;
  assign pop_w       = inv_valid_i & inv_ready_o;

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (push_w) req_ready_o[sel_w] = 1'b1;
    if (!empty_w) rsp_valid_o[head_w] = inv_valid_i;
  end

  always_comb begin
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q | (inv_valid_i & empty_w);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (push_w) begin
      ptr_d    = (sel_w == ID_W'(N_REQ - 1)) ? '0 : sel_w + 1'b1;
      lock_d   = 1'b0;
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr_q + 1'b1;
    end else if (inv_valid_o) begin
      lock_d    = 1'b1;
      lock_id_d = sel_w;
    end
    if (pop_w) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_w, pop_w})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Tag storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_w) tag_q[wr_ptr_q] <= sel_w;
  end

  assign inflight_o = cnt_q;
  assign busy_o     = (cnt_q != '0);
  assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sfm_acc_den_inv_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sfm_acc_den_inv_arbiter : directed-vector bench for the inverter arbiter.
// Revision 1.0
// ============================================================================
module tb_sfm_acc_den_inv_arbiter;

  logic         clk;
  logic         rst;
  logic         clear;
  logic [3:0]   req_valid;
  logic [127:0] req_den;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_inv;
  logic [3:0]   rsp_ready;
  logic         inv_valid_o;
  logic [31:0]  inv_den;
  logic         inv_ready_i;
  logic         inv_valid_i;
  logic [31:0]  inv_res;
  logic         inv_ready_o;
  logic [2:0]   inflight;
  logic         busy;
  logic         err;

  int vectors = 0;
  int miscompares = 0;

  sfm_acc_den_inv_arbiter #(.N_REQ(4), .WIDTH(32), .MAX_INFLIGHT(4)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .req_valid_i(req_valid), .req_den_i(req_den), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_inv_o(rsp_inv), .rsp_ready_i(rsp_ready),
    .inv_valid_o(inv_valid_o), .inv_den_o(inv_den), .inv_ready_i(inv_ready_i),
    .inv_valid_i(inv_valid_i), .inv_res_i(inv_res), .inv_ready_o(inv_ready_o),
    .inflight_o(inflight), .busy_o(busy), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change just after the falling edge; checks follow 1 ns later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = '0; rsp_ready = '0; inv_ready_i = 1'b0;
    inv_valid_i = 1'b0; inv_res = '0; clear = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1; tick(); rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL reset_inflight got %0d want 0", inflight); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (inv_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_inv_valid got %b want 0", inv_valid_o); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    vectors++; if (rsp_valid !== 4'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
  endtask

  task automatic test_single_lane();
    do_reset();
    req_den[2*32 +: 32] = 32'h4000_0000;
    req_valid = 4'b0100; inv_ready_i = 1'b1; #1;
    vectors++; if (inv_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_inv_valid got %b want 1", inv_valid_o); end
    vectors++; if (inv_den !== 32'h4000_0000) begin miscompares++; $display("FAIL single_den got %h want 40000000", inv_den); end
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_req_ready got %b want 0100", req_ready); end
    tick(); req_valid = '0; inv_ready_i = 1'b0; #1;
    vectors++; if (inflight !== 3'd1) begin miscompares++; $display("FAIL single_inflight1 got %0d want 1", inflight); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy1 got %b want 1", busy); end
    inv_valid_i = 1'b1; inv_res = 32'h3F00_0000; rsp_ready = 4'b0100; #1;
    vectors++; if (rsp_valid !== 4'b0100) begin miscompares++; $display("FAIL single_rsp_valid got %b want 0100", rsp_valid); end
    vectors++; if (rsp_inv !== 32'h3F00_0000) begin miscompares++; $display("FAIL single_rsp_inv got %h want 3f000000", rsp_inv); end
    vectors++; if (inv_ready_o !== 1'b1) begin miscompares++; $display("FAIL single_inv_ready got %b want 1", inv_ready_o); end
    tick(); idle_inputs(); #1;
    vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL single_inflight0 got %0d want 0", inflight); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy0 got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 4; k++) req_den[k*32 +: 32] = 32'h1000 + k;
    req_valid = 4'b1111; inv_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (inv_den !== 32'h1000 + k) begin miscompares++; $display("FAIL rr_issue%0d got %h want %h", k, inv_den, 32'h1000 + k); end
      vectors++; if (req_ready !== 4'(1 << k)) begin miscompares++; $display("FAIL rr_ready%0d got %b want %b", k, req_ready, 4'(1 << k)); end
      tick();
    end
    #1;
    vectors++; if (inv_valid_o !== 1'b0) begin miscompares++; $display("FAIL rr_full_valid got %b want 0", inv_valid_o); end
    req_valid = '0; inv_ready_i = 1'b0; rsp_ready = 4'b1111; inv_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      inv_res = 32'h5000 + k; #1;
      vectors++; if (rsp_valid !== 4'(1 << k)) begin miscompares++; $display("FAIL rr_rsp%0d got %b want %b", k, rsp_valid, 4'(1 << k)); end
      tick();
    end
    idle_inputs(); #1;
    vectors++; if (inflight !== 3'd0) begin miscompares++; $display("FAIL rr_drain got %0d want 0", inflight); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 4; k++) req_den[k*32 +: 32] = 32'hA000 + k;
    req_valid = 4'b1010; inv_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (inv_valid_o !== 1'b1 || inv_den !== 32'hA001 || req_ready !== 4'b0) begin
        miscompares++; $display("FAIL stall_c%0d got v=%b den=%h rdy=%b want v=1 den=0000a001 rdy=0000", c, inv_valid_o, inv_den, req_ready);
      end
      tick();
      // A lower-numbered lane joining mid-stall must not steal the grant.
      if (c == 0) req_valid = 4'b1011;
    end
    inv_ready_i = 1'b1; #1;
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL stall_accept1 got %b want 0010", req_ready); end
    tick(); req_valid = 4'b1001; #1;
    vectors++; if (req_ready !== 4'b1000 || inv_den !== 32'hA003) begin miscompares++; $display("FAIL stall_accept3 got rdy=%b den=%h want 1000 0000a003", req_ready, inv_den); end
    tick(); req_valid = 4'b0001; #1;
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL stall_accept0 got %b want 0001", req_ready); end
    tick(); idle_inputs(); #1;
    vectors++; if (inflight !== 3'd3) begin miscompares++; $display("FAIL stall_inflight got %0d want 3", inflight); end
  endtask

  task automatic test_full();
    int accepts;
    do_reset();
    for (int k = 0; k < 4; k++) req_den[k*32 +: 32] = 32'hB000 + k;
    accepts = 0;
    req_valid = 4'b1111; inv_ready_i = 1'b1; rsp_ready = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      #1; if (req_ready != 4'b0) accepts++;
      tick();
    end
    #1;
    vectors++; if (accepts != 4) begin miscompares++; $display("FAIL full_accepts got %0d want 4", accepts); end
    vectors++; if (inv_valid_o !== 1'b0 || inflight !== 3'd4) begin miscompares++; $display("FAIL full_state got v=%b n=%0d want v=0 n=4", inv_valid_o, inflight); end
    inv_valid_i = 1'b1; inv_res = 32'hCAFE; rsp_ready = 4'b0001; #1;
    vectors++; if (rsp_valid !== 4'b0001 || inv_ready_o !== 1'b1 || inv_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL full_pop got rsp=%b rdy=%b v=%b want 0001 1 0", rsp_valid, inv_ready_o, inv_valid_o);
    end
    tick(); inv_valid_i = 1'b0; rsp_ready = 4'b0000; #1;
    vectors++; if (inflight !== 3'd3 || inv_valid_o !== 1'b1 || req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL full_reissue got n=%0d v=%b rdy=%b want 3 1 0001", inflight, inv_valid_o, req_ready);
    end
    tick(); #1;
    vectors++; if (inflight !== 3'd4) begin miscompares++; $display("FAIL full_refill got %0d want 4", inflight); end
    idle_inputs();
  endtask

  task automatic test_clear();
    do_reset();
    for (int k = 0; k < 4; k++) req_den[k*32 +: 32] = 32'hD000 + k;
    req_valid = 4'b0111; inv_ready_i = 1'b1;
    tick(); tick(); tick();
    req_valid = '0; #1;
    vectors++; if (inflight !== 3'd3) begin miscompares++; $display("FAIL clear_pre got %0d want 3", inflight); end
    clear = 1'b1; tick(); clear = 1'b0; #1;
    vectors++; if (inflight !== 3'd0 || busy !== 1'b0 || inv_valid_o !== 1'b0 || rsp_valid !== 4'b0) begin
      miscompares++; $display("FAIL clear_state got n=%0d b=%b v=%b rsp=%b want 0 0 0 0000", inflight, busy, inv_valid_o, rsp_valid);
    end
    // Pointer back at 0: lane 0 beats lane 3 (it would lose with pointer 3).
    req_valid = 4'b1001; #1;
    vectors++; if (inv_den !== 32'hD000) begin miscompares++; $display("FAIL clear_ptr got %h want 0000d000", inv_den); end
    req_valid = 4'b1000; #1;
    vectors++; if (req_ready !== 4'b1000 || inv_den !== 32'hD003) begin miscompares++; $display("FAIL clear_lane3 got rdy=%b den=%h want 1000 0000d003", req_ready, inv_den); end
    tick(); req_valid = '0; inv_ready_i = 1'b0;
    inv_valid_i = 1'b1; inv_res = 32'h1234; rsp_ready = 4'b1111; #1;
    vectors++; if (rsp_valid !== 4'b1000) begin miscompares++; $display("FAIL clear_rsp3 got %b want 1000", rsp_valid); end
    tick(); idle_inputs(); #1;
    vectors++; if (err !== 1'b0 || inflight !== 3'd0) begin miscompares++; $display("FAIL clear_end got err=%b n=%0d want 0 0", err, inflight); end
  endtask

  task automatic test_error();
    do_reset();
    inv_valid_i = 1'b1; inv_res = 32'hDEAD; rsp_ready = 4'b1111; #1;
    vectors++; if (rsp_valid !== 4'b0 || inv_ready_o !== 1'b0) begin miscompares++; $display("FAIL err_rsp got rsp=%b rdy=%b want 0000 0", rsp_valid, inv_ready_o); end
    tick(); inv_valid_i = 1'b0; #1;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_set got %b want 1", err); end
    tick(); tick(); #1;
    vectors++; if (err !== 1'b1 || inflight !== 3'd0) begin miscompares++; $display("FAIL err_sticky got err=%b n=%0d want 1 0", err, inflight); end
    do_reset();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_cleared got %b want 0", err); end
  endtask

  initial begin
    rst = 1'b1;
    req_den = '0;
    idle_inputs();
    tick();
    test_reset();
    test_single_lane();
    test_round_robin();
    test_stall();
    test_full();
    test_clear();
    test_error();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
